// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared types and constants for the multicycle MIPS-style control unit:
//   - state_t     : FSM state encoding
//   - op_class_t  : instruction class produced by ctrl_decode
//   - br_kind_t   : branch condition selector
//   - OP_*        : opcode constants (Instr[31:26])
//   - ALU_*       : ALU function codes
//   - IMM_*       : immediate-extension modes
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_IF   = 3'd1,
        S_DEC  = 3'd2,
        S_EXEC = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE   = 3'd0,
        C_ALUI    = 3'd1,
        C_BRANCH  = 3'd2,
        C_LOAD    = 3'd3,
        C_STORE   = 3'd4,
        C_ILLEGAL = 3'd5
    } op_class_t;

    typedef enum logic [1:0] {
        BR_ALWAYS = 2'd0,
        BR_EQ     = 2'd1,
        BR_NE     = 2'd2
    } br_kind_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_NANDI = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    // ALU function codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_NAND = 4'b0101;

    // Immediate-extension modes
    localparam logic [1:0] IMM_SEXT     = 2'b00;
    localparam logic [1:0] IMM_ZFILL    = 2'b01;
    localparam logic [1:0] IMM_HI16     = 2'b10;
    localparam logic [1:0] IMM_SEXT_SH2 = 2'b11;

endpackage : multicycle_ctrl_pkg

// File: rtl/multicycle_control_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Purely combinational opcode decoder. Classifies Instr[31:26] and returns the
// per-opcode attributes the FSM needs in EXEC and MEM.
// Ports:
//   opcode   in  6 : Instr[31:26]
//   op_class out   : instruction class (C_ILLEGAL for undefined opcodes)
//   imm_ext  out 2 : immediate mode used in EXEC
//   alu_op   out 4 : ALU function for non-R-type instructions
//   byte_op  out 1 : lb / sb
//   br_kind  out   : branch condition (b / beq / bne)
// -----------------------------------------------------------------------------
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class,
    output logic [1:0] imm_ext,
    output logic [3:0] alu_op,
    output logic       byte_op,
    output br_kind_t   br_kind
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        op_class = C_ILLEGAL;
        imm_ext  = IMM_SEXT;
        alu_op   = ALU_ADD;
        byte_op  = 1'b0;
        br_kind  = BR_ALWAYS;

        case (opcode)
            OP_RTYPE: op_class = C_RTYPE;
            OP_LI, OP_ADDI: op_class = C_ALUI;
            OP_LUI: begin
                op_class = C_ALUI;
                imm_ext  = IMM_HI16;
            end
            OP_NANDI: begin
                op_class = C_ALUI;
                imm_ext  = IMM_ZFILL;
                alu_op   = ALU_NAND;
            end
            OP_ORI: begin
                op_class = C_ALUI;
                imm_ext  = IMM_ZFILL;
                alu_op   = ALU_OR;
            end
            OP_B, OP_BEQ, OP_BNE: begin
                op_class = C_BRANCH;
                imm_ext  = IMM_SEXT_SH2;
                alu_op   = ALU_SUB;
                br_kind  = (opcode == OP_B)   ? BR_ALWAYS :
                           (opcode == OP_BEQ) ? BR_EQ : BR_NE;
            end
            OP_LW: op_class = C_LOAD;
            OP_LB: begin
                op_class = C_LOAD;
                byte_op  = 1'b1;
            end
            OP_SW: op_class = C_STORE;
            OP_SB: begin
                op_class = C_STORE;
                byte_op  = 1'b1;
            end
            default: op_class = C_ILLEGAL;
        endcase
    end

endmodule : ctrl_decode

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Multicycle control FSM (RST, IF, DEC, EXEC, MEM, WB). One instruction at a
// time; outputs are a combinational function of the registered state, the
// opcode (via ctrl_decode), Zero in EXEC and, optionally, Mem_Ready in MEM.
// Illegal_Op is a sticky register cleared only by reset.
//
// Optional feature: define MULTICYCLE_MEM_WAIT_EN to hold MEM until Mem_Ready=1.
// Without it MEM lasts one cycle and Mem_Ready is ignored.
//
// Ports:
//   Clk, Reset_n (async, active-low)
//   Instr[31:0], Zero, Mem_Ready                      : inputs
//   Instr_LdEn, PC_LdEn, PC_sel                        : fetch / PC control
//   RF_WrEn, RF_WrData_sel, RF_B_sel, ImmExt[1:0]      : decode-stage control
//   ALU_Bin_sel, ALU_func[ALU_FUNC_W-1:0]              : ALU control
//   Mem_RdEn, Mem_WrEn, ByteOp                         : data memory control
//   Illegal_Op                                         : sticky undefined-opcode flag
// -----------------------------------------------------------------------------
module multicycle_control
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALU_FUNC_W = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [31:0]           Instr,
    input  logic                  Zero,
    input  logic                  Mem_Ready,
    output logic                  Instr_LdEn,
    output logic                  PC_LdEn,
    output logic                  PC_sel,
    output logic                  RF_WrEn,
    output logic                  RF_WrData_sel,
    output logic                  RF_B_sel,
    output logic [1:0]            ImmExt,
    output logic                  ALU_Bin_sel,
    output logic [ALU_FUNC_W-1:0] ALU_func,
    output logic                  Mem_RdEn,
    output logic                  Mem_WrEn,
    output logic                  ByteOp,
    output logic                  Illegal_Op
);

    state_t     state;
    logic       illegal_q;
    op_class_t  op_class;
    logic [1:0] imm_ext;
    logic [3:0] alu_op;
    logic       byte_op;
    br_kind_t   br_kind;
    logic       mem_done;

    ctrl_decode u_decode (
        .opcode   (Instr[31:26]),
        .op_class (op_class),
        .imm_ext  (imm_ext),
        .alu_op   (alu_op),
        .byte_op  (byte_op),
        .br_kind  (br_kind)
    );

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_done = Mem_Ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = Mem_Ready;
    assign mem_done         = 1'b1;
`endif

    // Only the opcode and the R-type function field are interpreted here.
    logic unused_instr;
    assign unused_instr = ^Instr[25:4];

    // NOTE: state is sequential, so it is updated with non-blocking (<=)
    // assignments only; the combinational block below uses blocking (=).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_RST;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_RST: state <= S_IF;
                S_IF:  state <= S_DEC;
                S_DEC: begin
                    if (op_class == C_ILLEGAL) begin
                        state     <= S_IF;
                        illegal_q <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_class)
                        C_LOAD, C_STORE: state <= S_MEM;
                        C_BRANCH:        state <= S_IF;
                        default:         state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_done) state <= (op_class == C_LOAD) ? S_WB : S_IF;
                end
                S_WB:    state <= S_IF;
                default: state <= S_RST;
            endcase
        end
    end

    assign Illegal_Op = illegal_q;

    always_comb begin
        Instr_LdEn    = 1'b0;
        PC_LdEn       = 1'b0;
        PC_sel        = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ImmExt        = IMM_SEXT;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = '0;
        Mem_RdEn      = 1'b0;
        Mem_WrEn      = 1'b0;
        ByteOp        = 1'b0;

        case (state)
            S_IF: Instr_LdEn = 1'b1;
            S_DEC: begin
                // Illegal opcodes skip the instruction: advance PC to PC+4.
                if (op_class == C_ILLEGAL) PC_LdEn = 1'b1;
            end
            S_EXEC: begin
                case (op_class)
                    C_RTYPE: ALU_func = ALU_FUNC_W'(Instr[3:0]);
                    C_ALUI: begin
                        ALU_Bin_sel = 1'b1;
                        ImmExt      = imm_ext;
                        ALU_func    = ALU_FUNC_W'(alu_op);
                    end
                    C_LOAD, C_STORE: begin
                        ALU_Bin_sel = 1'b1;
                        ImmExt      = IMM_SEXT;
                        ALU_func    = ALU_FUNC_W'(ALU_ADD);
                    end
                    C_BRANCH: begin
                        // rs - rd compare sets Zero; the target offset is
                        // sign-extended and shifted by 2.
                        ALU_func = ALU_FUNC_W'(ALU_SUB);
                        RF_B_sel = 1'b1;
                        ImmExt   = IMM_SEXT_SH2;
                        PC_LdEn  = 1'b1;
                        case (br_kind)
                            BR_EQ:   PC_sel = Zero;
                            BR_NE:   PC_sel = ~Zero;
                            default: PC_sel = 1'b1;
                        endcase
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ByteOp = byte_op;
                if (op_class == C_LOAD) begin
                    Mem_RdEn = 1'b1;
                end else begin
                    Mem_WrEn = 1'b1;
                    RF_B_sel = 1'b1;
                    // With wait states the store retires only on the ready cycle.
                    PC_LdEn  = mem_done;
                end
            end
            S_WB: begin
                RF_WrEn       = 1'b1;
                RF_WrData_sel = (op_class == C_LOAD);
                PC_LdEn       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule : multicycle_control

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Scoreboard bench: the stimulus process computes the expected output vector
// for every cycle from the instruction-class rules and pushes it (plus the
// expected cycles-per-instruction) into queues; a monitor on the falling edge
// pops and compares. Honours MULTICYCLE_MEM_WAIT_EN the same way as the DUT.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    typedef struct packed {
        logic       instr_ld;
        logic       pc_ld;
        logic       pc_sel;
        logic       rf_wr;
        logic       rf_wd_sel;
        logic       rf_b_sel;
        logic [1:0] imm_ext;
        logic       bin_sel;
        logic [3:0] alu_func;
        logic       mem_rd;
        logic       mem_wr;
        logic       byte_op;
        logic       illegal;
    } outs_t;

    typedef struct {
        outs_t exp;
        outs_t mask;
        string tag;
    } exp_t;

    // Instruction classes as seen by the reference model
    localparam int K_R = 0, K_ALUI = 1, K_BR = 2, K_LD = 3, K_ST = 4, K_ILL = 5;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic [31:0] Instr = '0;
    logic        Zero = 1'b0;
    logic        Mem_Ready = 1'b0;
    logic        Instr_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel;
    logic [1:0]  ImmExt;
    logic        ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic        Mem_RdEn, Mem_WrEn, ByteOp, Illegal_Op;

    exp_t  exp_q[$];
    int    len_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    sticky = 1'b0;
    outs_t act;

    multicycle_control #(.ALU_FUNC_W(4)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Instr         (Instr),
        .Zero          (Zero),
        .Mem_Ready     (Mem_Ready),
        .Instr_LdEn    (Instr_LdEn),
        .PC_LdEn       (PC_LdEn),
        .PC_sel        (PC_sel),
        .RF_WrEn       (RF_WrEn),
        .RF_WrData_sel (RF_WrData_sel),
        .RF_B_sel      (RF_B_sel),
        .ImmExt        (ImmExt),
        .ALU_Bin_sel   (ALU_Bin_sel),
        .ALU_func      (ALU_func),
        .Mem_RdEn      (Mem_RdEn),
        .Mem_WrEn      (Mem_WrEn),
        .ByteOp        (ByteOp),
        .Illegal_Op    (Illegal_Op)
    );

    always #5 Clk = ~Clk;

    assign act = {Instr_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel,
                  ImmExt, ALU_Bin_sel, ALU_func, Mem_RdEn, Mem_WrEn, ByteOp, Illegal_Op};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int classify(input logic [5:0] op);
        case (op)
            6'b100000:                                  return K_R;
            6'b111000, 6'b111001, 6'b110000,
            6'b110010, 6'b110011:                       return K_ALUI;
            6'b111111, 6'b000000, 6'b000001:            return K_BR;
            6'b000011, 6'b001111:                       return K_LD;
            6'b000111, 6'b011111:                       return K_ST;
            default:                                    return K_ILL;
        endcase
    endfunction

    function automatic outs_t base();
        outs_t e = '0;
        e.illegal = sticky;
        return e;
    endfunction

    // Queue the expected vector for the current cycle, then advance one cycle.
    task automatic push(input outs_t e, input string tag, input bit alu_dc = 1'b0);
        exp_t x;
        x.exp  = e;
        x.mask = '1;
        if (alu_dc) x.mask.alu_func = '0;
        x.tag  = tag;
        exp_q.push_back(x);
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_rand();
        Zero      = 1'($urandom);
        Mem_Ready = 1'($urandom);
    endtask

    // n cycles with reset held low, then release and expect one RST cycle.
    task automatic reset_tail(input int n);
        for (int i = 0; i < n; i++) push('0, "in_reset");
        Reset_n = 1'b1;
        push('0, "rst_state");
    endtask

    // zsel: -1 random Zero in EXEC, else forced. waits: Mem_Ready-low cycles.
    task automatic run_instr(input logic [31:0] ins, input int waits, input int zsel, input bit abort);
        logic [5:0] op;
        int         k, len, w_eff;
        bit         is_byte;
        outs_t      e;
        op      = ins[31:26];
        k       = classify(op);
        is_byte = (op == 6'b000011) || (op == 6'b000111);
`ifdef MULTICYCLE_MEM_WAIT_EN
        w_eff = waits;
`else
        w_eff = 0;
`endif
        case (k)
            K_ILL:   len = 2;
            K_BR:    len = 3;
            K_LD:    len = 5 + w_eff;
            K_ST:    len = 4 + w_eff;
            default: len = 4;
        endcase
        len_q.push_back(len);

        Instr = ins;
        drive_rand();
        e = base(); e.instr_ld = 1'b1;
        push(e, "IF");

        drive_rand();
        e = base();
        if (k == K_ILL) begin
            e.pc_ld = 1'b1;
            push(e, "DEC_illegal");
            sticky = 1'b1;
            return;
        end
        push(e, "DEC");

        drive_rand();
        if (zsel >= 0) Zero = 1'(zsel);
        e = base();
        case (k)
            K_R: e.alu_func = ins[3:0];
            K_ALUI: begin
                e.bin_sel  = 1'b1;
                e.imm_ext  = (op == 6'b110011 || op == 6'b110010) ? 2'b01 :
                             (op == 6'b111001) ? 2'b10 : 2'b00;
                e.alu_func = (op == 6'b110011) ? 4'b0011 :
                             (op == 6'b110010) ? 4'b0101 : 4'b0000;
            end
            K_BR: begin
                e.alu_func = 4'b0001;
                e.rf_b_sel = 1'b1;
                e.imm_ext  = 2'b11;
                e.pc_ld    = 1'b1;
                e.pc_sel   = (op == 6'b111111) ? 1'b1 : (op == 6'b000000) ? Zero : ~Zero;
            end
            default: begin
                e.bin_sel  = 1'b1;
                e.alu_func = 4'b0000;
            end
        endcase
        // li / lui ALU operation is not pinned down, so it is not compared.
        push(e, "EXEC", (op == 6'b111000 || op == 6'b111001));
        if (k == K_BR) return;

        if (k == K_LD || k == K_ST) begin
            for (int w = 0; w <= w_eff; w++) begin
                drive_rand();
`ifdef MULTICYCLE_MEM_WAIT_EN
                Mem_Ready = (w == w_eff);
`endif
                e = base();
                e.byte_op = is_byte;
                if (k == K_LD) begin
                    e.mem_rd = 1'b1;
                end else begin
                    e.mem_wr   = 1'b1;
                    e.rf_b_sel = 1'b1;
                    e.pc_ld    = (w == w_eff);
                end
                if (abort) begin
                    // Expect this MEM cycle, then pull reset mid-cycle.
                    exp_t x;
                    x.exp = e; x.mask = '1; x.tag = "MEM_before_abort";
                    exp_q.push_back(x);
                    @(negedge Clk);
                    #2;
                    Reset_n = 1'b0;
                    sticky  = 1'b0;
                    #1;
                    check("async_rst_mem_wr", 32'(Mem_WrEn), 32'd0);
                    check("async_rst_outs", 32'(act), 32'd0);
                    @(posedge Clk);
                    #1;
                    reset_tail(2);
                    return;
                end
                push(e, "MEM");
            end
            if (k == K_ST) return;
        end

        drive_rand();
        e = base();
        e.rf_wr     = 1'b1;
        e.rf_wd_sel = (k == K_LD);
        e.pc_ld     = 1'b1;
        push(e, "WB");
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] legal [13] = '{6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010,
                                   6'b110011, 6'b111111, 6'b000000, 6'b000001, 6'b000011,
                                   6'b001111, 6'b000111, 6'b011111};
        logic [31:0] r;
        logic [5:0]  op;
        r = $urandom;
        if ($urandom_range(0, 9) == 0) begin
            op = 6'($urandom);
            while (classify(op) != K_ILL) op = 6'($urandom);
        end else begin
            op = legal[$urandom_range(0, 12)];
        end
        r[31:26] = op;
        return r;
    endfunction

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(negedge Clk) begin
        if (exp_q.size() != 0) begin
            exp_t x;
            x = exp_q.pop_front();
            check(x.tag, 32'(act & x.mask), 32'(x.exp & x.mask));
        end
        if (Instr_LdEn) cyc = 1;
        else cyc++;
        if (PC_LdEn) begin
            if (len_q.size() == 0) check("cpi_unexpected_pc_ld", 32'd1, 32'd0);
            else check("cpi", 32'(cyc), 32'(len_q.pop_front()));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        #1 Reset_n = 1'b0;
        @(posedge Clk);
        #1;
        reset_tail(3);

        run_instr(32'h8023_1030, 0, -1, 1'b0);   // add r3,r1,r2
        run_instr(32'h0022_0004, 0, 1, 1'b0);    // beq taken
        run_instr(32'h0022_0004, 0, 0, 1'b0);    // beq not taken
        run_instr(32'h3C01_0008, 2, -1, 1'b0);   // lw with two wait cycles
        run_instr(32'h5400_0000, 0, -1, 1'b0);   // illegal
        for (int i = 0; i < 150; i++)
            run_instr(rand_instr(), int'($urandom_range(0, 3)), -1, 1'b0);
        run_instr(32'h7C01_0008, 0, -1, 1'b1);   // sw, reset mid-MEM
        for (int i = 0; i < 60; i++)
            run_instr(rand_instr(), int'($urandom_range(0, 3)), -1, 1'b0);

        @(posedge Clk);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("len_q_drained", 32'(len_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (checks %0d)", checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_multicycle_control
